// File: rtl/encode16_event.sv
// Sequential 16-to-4 event encoder: synchronises request lines, latches rising edges as
// pending events and presents them one at a time as a 4-bit code over valid/ready.
module encode16_event #(
  parameter int SYNC_STAGES = 2,
  parameter bit HIGH_FIRST  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req,
  input  logic        ready,
  output logic [3:0]  code,
  output logic        valid,
  output logic [15:0] pending,
  output logic        none,
  output logic        overflow
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t                        state, state_nxt;
  logic [3:0]                    code_nxt;
  logic [SYNC_STAGES-1:0][15:0]  sync_p0;
  logic [15:0]                   prev_p1;
  logic [15:0]                   rise_p1;
  logic [15:0]                   clr;

  function automatic logic [3:0] prio_enc(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 16; i++)
        if (v[i]) idx = 4'(i);
    end else begin
      for (int i = 15; i >= 0; i--)
        if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Stage p0: metastability chain, one row of 16 flops per stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
    end else if (SYNC_STAGES > 1) begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], req};
    end else begin
      sync_p0 <= req;
    end
  end

  // Stage p1: edge detect against the previous synchronised sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_p1 <= '0;
    else       prev_p1 <= sync_p0[SYNC_STAGES-1];
  end

  assign rise_p1 = sync_p0[SYNC_STAGES-1] & ~prev_p1;
  assign clr     = (valid && ready) ? (16'd1 << code) : 16'd0;

  // A rise on the bit being cleared re-sets it, so an edge during accept is never lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= (pending & ~clr) | rise_p1;
      overflow <= |(rise_p1 & pending & ~clr);
    end
  end

  assign none  = (pending == 16'd0);
  assign valid = (state == PRESENT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      code  <= '0;
    end else begin
      state <= state_nxt;
      code  <= code_nxt;
    end
  end

  // No preemption: code is only reloaded from IDLE, giving one bubble after each accept
  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    case (state)
      IDLE: begin
        if (pending != 16'd0) begin
          code_nxt  = prio_enc(pending);
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_encode16_event.sv
// Bench for encode16_event: both priority orders side by side, a cycle-level reference
// model, a table of simultaneous-edge vectors, directed corner sequences and random traffic.
module tb_encode16_event;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] req = '0;
  logic        ready = 1'b0;

  logic [3:0]  code_h, code_l;
  logic        valid_h, valid_l, none_h, none_l, ovf_h, ovf_l;
  logic [15:0] pending_h, pending_l;

  int checks = 0;
  int errors = 0;
  int ovf_cnt_h = 0;
  int ovf_cnt_l = 0;
  int acc_h[$];
  int acc_l[$];

  encode16_event #(.SYNC_STAGES(S), .HIGH_FIRST(1'b1)) dut_h (
    .clk(clk), .reset(reset), .req(req), .ready(ready),
    .code(code_h), .valid(valid_h), .pending(pending_h), .none(none_h), .overflow(ovf_h)
  );

  encode16_event #(.SYNC_STAGES(S), .HIGH_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .req(req), .ready(ready),
    .code(code_l), .valid(valid_l), .pending(pending_l), .none(none_l), .overflow(ovf_l)
  );

  always #5 clk = ~clk;

  // Reference model: req history as a delay line, pending set as a bit vector,
  // "presenting" flag plus code.
  typedef struct packed {
    logic [S:0][15:0] hist;
    logic [15:0]      pend;
    logic [3:0]       code;
    logic             vld;
    logic             ovf;
  } mstate_t;

  mstate_t mh = '0;
  mstate_t ml = '0;

  function automatic logic [3:0] pick(input logic [15:0] p, input bit hf);
    int best;
    best = 0;
    if (hf) begin
      for (int i = 0; i < 16; i++) if (p[i]) best = i;
    end else begin
      for (int i = 15; i >= 0; i--) if (p[i]) best = i;
    end
    return 4'(best);
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic [15:0] r,
                                   input logic rdy, input bit hf);
    mstate_t     n;
    logic [15:0] rise, clr;
    n    = s;
    rise = s.hist[S-1] & ~s.hist[S];
    clr  = (s.vld && rdy) ? (16'd1 << s.code) : 16'd0;
    n.pend = (s.pend & ~clr) | rise;
    n.ovf  = |(rise & s.pend & ~clr);
    if (!s.vld && s.pend != 16'd0) begin
      n.code = pick(s.pend, hf);
      n.vld  = 1'b1;
    end else if (s.vld && rdy) begin
      n.vld = 1'b0;
    end
    n.hist = {s.hist[S-1:0], r};
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mh <= '0;
      ml <= '0;
    end else begin
      mh <= step(mh, req, ready, 1'b1);
      ml <= step(ml, req, ready, 1'b0);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("valid_h",   64'(valid_h),   64'(mh.vld));
    chk("code_h",    64'(code_h),    64'(mh.code));
    chk("pending_h", 64'(pending_h), 64'(mh.pend));
    chk("none_h",    64'(none_h),    64'(mh.pend == 16'd0));
    chk("ovf_h",     64'(ovf_h),     64'(mh.ovf));
    chk("valid_l",   64'(valid_l),   64'(ml.vld));
    chk("code_l",    64'(code_l),    64'(ml.code));
    chk("pending_l", 64'(pending_l), 64'(ml.pend));
    chk("none_l",    64'(none_l),    64'(ml.pend == 16'd0));
    chk("ovf_l",     64'(ovf_l),     64'(ml.ovf));
  endtask

  // One clock: log accepts happening at this edge, then compare on the falling edge
  task automatic tick();
    if (valid_h && ready) acc_h.push_back(int'(code_h));
    if (valid_l && ready) acc_l.push_back(int'(code_l));
    @(posedge clk);
    @(negedge clk);
    if (ovf_h) ovf_cnt_h++;
    if (ovf_l) ovf_cnt_l++;
    cmp_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    acc_h.delete();
    acc_l.delete();
    ovf_cnt_h = 0;
    ovf_cnt_l = 0;
  endtask

  typedef struct {
    logic [15:0] mask;
    int          n;
    logic [63:0] hi;
    logic [63:0] lo;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{16'h0020, 1,  64'h5,                64'h5};
    tbl[1] = '{16'h1208, 3,  64'h39C,              64'hC93};
    tbl[2] = '{16'hFFFF, 16, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
    tbl[3] = '{16'h8001, 2,  64'h0F,               64'hF0};

    #1 reset = 1'b1;
    #1;
    chk("rst_valid",   64'(valid_h),   64'd0);
    chk("rst_code",    64'(code_h),    64'd0);
    chk("rst_pending", 64'(pending_h), 64'd0);
    chk("rst_none",    64'(none_h),    64'd1);
    chk("rst_ovf",     64'(ovf_l),     64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Idle with req=0
    clear_logs();
    ticks(10);
    chk("idle_ovf_cnt", 64'(ovf_cnt_h + ovf_cnt_l), 64'd0);
    chk("idle_none",    64'(none_h),               64'd1);

    // First-event latency on line 5
    ready = 1'b1;
    req = 16'h0020;
    ticks(3);
    chk("lat_valid_e2", 64'(valid_h), 64'd0);
    tick();
    chk("lat_valid_e3", 64'(valid_h), 64'd1);
    chk("lat_code_e3",  64'(code_h),  64'd5);
    tick();
    chk("lat_valid_e4", 64'(valid_h),   64'd0);
    chk("lat_pend_e4",  64'(pending_h), 64'd0);
    req = '0;
    ticks(6);

    // Simultaneous edges, drained with ready held high
    for (int t = 0; t < 4; t++) begin
      ready = 1'b1;
      req = '0;
      ticks(6);
      clear_logs();
      req = tbl[t].mask;
      ticks(2 * tbl[t].n + 10);
      chk($sformatf("tbl%0d_cnt_h", t), 64'(acc_h.size()), 64'(tbl[t].n));
      chk($sformatf("tbl%0d_cnt_l", t), 64'(acc_l.size()), 64'(tbl[t].n));
      for (int i = 0; i < tbl[t].n; i++) begin
        if (i < acc_h.size())
          chk($sformatf("tbl%0d_h[%0d]", t, i), 64'(acc_h[i]), 64'(4'(tbl[t].hi >> (4 * i))));
        if (i < acc_l.size())
          chk($sformatf("tbl%0d_l[%0d]", t, i), 64'(acc_l[i]), 64'(4'(tbl[t].lo >> (4 * i))));
      end
    end
    req = '0;
    ticks(6);

    // No preemption: code 7 held while line 15 arrives
    ready = 1'b0;
    req = 16'h0080;
    ticks(3);
    req = '0;
    ticks(3);
    chk("hold_code7", 64'(code_h), 64'd7);
    req = 16'h8000;
    ticks(5);
    chk("hold_still7",  64'(code_h),    64'd7);
    chk("hold_valid",   64'(valid_h),   64'd1);
    chk("hold_pending", 64'(pending_h), 64'h8080);
    clear_logs();
    ready = 1'b1;
    ticks(6);
    chk("hold_cnt", 64'(acc_h.size()), 64'd2);
    if (acc_h.size() == 2) begin
      chk("hold_first",  64'(acc_h[0]), 64'd7);
      chk("hold_second", 64'(acc_h[1]), 64'd15);
    end
    req = '0;
    ticks(6);

    // Duplicate edge on a pending line merges and pulses overflow
    ready = 1'b0;
    clear_logs();
    req = 16'h0004; ticks(3);
    req = '0;       ticks(3);
    req = 16'h0004; ticks(3);
    req = '0;       ticks(4);
    chk("ovf_cnt_h", 64'(ovf_cnt_h), 64'd1);
    chk("ovf_cnt_l", 64'(ovf_cnt_l), 64'd1);
    ready = 1'b1;
    ticks(6);
    chk("ovf_events", 64'(acc_h.size()), 64'd1);
    if (acc_h.size() == 1) chk("ovf_code", 64'(acc_h[0]), 64'd2);
    ticks(4);

    // Edge on line 4 coinciding with the accept of code 4
    ready = 1'b0;
    req = 16'h0010; ticks(3);
    req = '0;       ticks(4);
    chk("col_pres", 64'(code_h), 64'd4);
    req = 16'h0010;
    ticks(2);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("col_valid0", 64'(valid_h),   64'd0);
    chk("col_pend",   64'(pending_h), 64'h0010);
    tick();
    chk("col_valid1", 64'(valid_h), 64'd1);
    chk("col_code",   64'(code_h),  64'd4);
    req = '0;
    ready = 1'b1;
    ticks(8);

    // Asynchronous reset while presenting, line 0 held through release
    ready = 1'b0;
    req = 16'h0100;
    ticks(5);
    chk("ar_pre_valid", 64'(valid_h), 64'd1);
    req = 16'h0001;
    #2 reset = 1'b1;
    #1;
    chk("ar_valid",   64'(valid_h),   64'd0);
    chk("ar_code",    64'(code_h),    64'd0);
    chk("ar_pending", 64'(pending_h), 64'd0);
    chk("ar_none",    64'(none_l),    64'd1);
    ticks(3);
    reset = 1'b0;
    ready = 1'b1;
    clear_logs();
    ticks(12);
    chk("ar_events", 64'(acc_h.size()), 64'd1);
    if (acc_h.size() == 1) chk("ar_code0", 64'(acc_h[0]), 64'd0);
    req = '0;
    ticks(6);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      req = req ^ 16'($urandom & $urandom & $urandom & $urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
